// File: rtl/alu_seq8.sv
// alu_seq8: multi-cycle 8-bit ALU feeding the accumulator register.
// Single-cycle ops go IDLE -> EXEC -> DONE. MUL goes IDLE -> MUL -> DONE.
// MUL runs eight shift-add iterations, then spends one cycle writing back.
// result_o and flags_o are held between done pulses; flags are {N,Z,V,C}.
module alu_seq8 #(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned MUL_CYCLES = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic [2:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             wen_o,
   output logic [WIDTH-1:0] result_o,
   output logic [3:0]       flags_o
);

   localparam int unsigned CntW = $clog2(MUL_CYCLES + 1);

   localparam logic [2:0] OpPass = 3'b000;
   localparam logic [2:0] OpAdd  = 3'b001;
   localparam logic [2:0] OpSub  = 3'b010;
   localparam logic [2:0] OpAnd  = 3'b011;
   localparam logic [2:0] OpOr   = 3'b100;
   localparam logic [2:0] OpNot  = 3'b101;
   localparam logic [2:0] OpMul  = 3'b110;
   localparam logic [2:0] OpRsvd = 3'b111;

   typedef enum logic [1:0] {StIdle, StExec, StMul, StDone} state_e;

   state_e               state_q, state_d;
   logic [2:0]           op_q, op_d;
   logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
   logic [2*WIDTH-1:0]   prod_q, prod_d;
   logic [2*WIDTH-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0]     mplier_q, mplier_d;
   logic [CntW-1:0]      cnt_q, cnt_d;
   logic [WIDTH-1:0]     result_q, result_d;
   logic [3:0]           flags_q, flags_d;

   logic [WIDTH-1:0]     alu_res;
   logic                 alu_v, alu_c;
   logic [WIDTH:0]       sum, diff;
   logic                 mul_hi_nz;

   // Single-cycle datapath on the latched operands.
   always_comb begin
      sum     = {1'b0, a_q} + {1'b0, b_q};
      diff    = {1'b0, a_q} - {1'b0, b_q};
      alu_res = b_q;
      alu_v   = 1'b0;
      alu_c   = 1'b0;
      case (op_q)
         OpPass: alu_res = b_q;
         OpAdd: begin
            alu_res = sum[WIDTH-1:0];
            alu_c   = sum[WIDTH];
            alu_v   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                      (sum[WIDTH-1] != a_q[WIDTH-1]);
         end
         OpSub: begin
            alu_res = diff[WIDTH-1:0];
            alu_c   = diff[WIDTH]; // borrow: A < B unsigned
            alu_v   = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                      (diff[WIDTH-1] != a_q[WIDTH-1]);
         end
         OpAnd:  alu_res = a_q & b_q;
         OpOr:   alu_res = a_q | b_q;
         OpNot:  alu_res = ~a_q;
         OpRsvd: alu_res = a_q; // behaves as PASS of A, no write-back
         default: alu_res = b_q;
      endcase
   end

   assign mul_hi_nz = |prod_q[2*WIDTH-1:WIDTH];

   // Next-state logic for the FSM and datapath registers.
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      prod_d   = prod_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      flags_d  = flags_q;
      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               op_d     = op_i;
               a_d      = a_i;
               b_d      = b_i;
               prod_d   = '0;
               mcand_d  = {{WIDTH{1'b0}}, a_i};
               mplier_d = b_i;
               cnt_d    = '0;
               state_d  = (op_i == OpMul) ? StMul : StExec;
            end
         end
         StExec: begin
            result_d = alu_res;
            flags_d  = {alu_res[WIDTH-1], (alu_res == '0), alu_v, alu_c};
            state_d  = StDone;
         end
         StMul: begin
            if (cnt_q == CntW'(MUL_CYCLES)) begin
               // Product complete; write back low byte with overflow flags.
               result_d = prod_q[WIDTH-1:0];
               flags_d  = {prod_q[WIDTH-1], (prod_q[WIDTH-1:0] == '0),
                           mul_hi_nz, mul_hi_nz};
               state_d  = StDone;
            end else begin
               if (mplier_q[0]) begin
                  prod_d = prod_q + mcand_q;
               end
               mcand_d  = mcand_q << 1;
               mplier_d = mplier_q >> 1;
               cnt_d    = cnt_q + 1'b1;
            end
         end
         StDone: state_d = StIdle;
      endcase
   end

   // State and datapath registers, cleared immediately by reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= StIdle;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         prod_q   <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         flags_q  <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         prod_q   <= prod_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         flags_q  <= flags_d;
      end
   end

   // Handshake outputs decode straight from the state register.
   assign busy_o   = (state_q != StIdle);
   assign done_o   = (state_q == StDone);
   assign wen_o    = (state_q == StDone) && (op_q != OpRsvd);
   assign result_o = result_q;
   assign flags_o  = flags_q;

endmodule

// File: tb/tb_alu_seq8.sv
// tb_alu_seq8: directed vectors with hand-computed expectations for alu_seq8.
module tb_alu_seq8;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [2:0] op;
   logic [7:0] a, b;
   logic       busy, done, wen;
   logic [7:0] result;
   logic [3:0] flags;

   int vectors = 0;
   int miscompares = 0;

   alu_seq8 #(.WIDTH(8), .MUL_CYCLES(8)) dut (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .start_i  (start),
      .op_i     (op),
      .a_i      (a),
      .b_i      (b),
      .busy_o   (busy),
      .done_o   (done),
      .wen_o    (wen),
      .result_o (result),
      .flags_o  (flags)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one op from IDLE and check latency, busy, result, flags and write strobe.
   task automatic do_op(input string tag, input logic [2:0] o, input logic [7:0] va,
                        input logic [7:0] vb, input int exp_lat, input logic [7:0] exp_res,
                        input logic [3:0] exp_flags, input logic exp_wen);
      int  lat;
      logic busy_ok;
      start = 1'b1;
      op    = o;
      a     = va;
      b     = vb;
      tick();
      start = 1'b0;
      a     = ~va; // in-flight result must not follow the live operands
      b     = ~vb;
      lat     = 0;
      busy_ok = 1'b1;
      for (int n = 1; n <= 20; n++) begin
         if (!busy) busy_ok = 1'b0;
         tick();
         if (done) begin
            lat = n;
            break;
         end
      end
      chk({tag, ".latency"}, 16'(lat), 16'(exp_lat));
      chk({tag, ".busy"}, {15'd0, busy_ok & busy}, 16'd1);
      chk({tag, ".result"}, {8'd0, result}, {8'd0, exp_res});
      chk({tag, ".flags"}, {12'd0, flags}, {12'd0, exp_flags});
      chk({tag, ".wen"}, {15'd0, wen}, {15'd0, exp_wen});
      tick();
      chk({tag, ".idle"}, {13'd0, busy, done, wen}, 16'd0);
      chk({tag, ".hold"}, {4'd0, flags, result}, {4'd0, exp_flags, exp_res});
   endtask

   initial begin
      int dones;
      int wens;
      int done_at;
      logic [7:0] cap_res;
      logic [3:0] cap_flags;

      rst_n = 1'b0;
      start = 1'b0;
      op    = 3'd0;
      a     = 8'd0;
      b     = 8'd0;
      #12;
      chk("reset.outputs", {3'd0, busy, done, wen, flags, result}, 16'd0);
      rst_n = 1'b1;
      tick();
      chk("reset.idle", {13'd0, busy, done, wen}, 16'd0);

      // flags are {N,Z,V,C}
      do_op("add7f01", 3'b001, 8'h7F, 8'h01, 1, 8'h80, 4'b1010, 1'b1);
      do_op("sub0505", 3'b010, 8'h05, 8'h05, 1, 8'h00, 4'b0100, 1'b1);
      do_op("sub0305", 3'b010, 8'h03, 8'h05, 1, 8'hFE, 4'b1001, 1'b1);
      do_op("mul0c11", 3'b110, 8'h0C, 8'h11, 9, 8'hCC, 4'b1000, 1'b1);
      do_op("mul2010", 3'b110, 8'h20, 8'h10, 9, 8'h00, 4'b0111, 1'b1);
      do_op("or8001",  3'b100, 8'h80, 8'h01, 1, 8'h81, 4'b1000, 1'b1);
      do_op("notff",   3'b101, 8'hFF, 8'h00, 1, 8'h00, 4'b0100, 1'b1);
      do_op("pass9c",  3'b000, 8'h12, 8'h9C, 1, 8'h9C, 4'b1000, 1'b1);

      // start pulse mid-MUL must be ignored
      start = 1'b1;
      op    = 3'b110;
      a     = 8'h0C;
      b     = 8'h11;
      tick();
      start = 1'b0;
      dones = 0;
      done_at = 0;
      cap_res = 8'h00;
      cap_flags = 4'h0;
      for (int n = 1; n <= 16; n++) begin
         if (n == 3) begin
            start = 1'b1;
            op    = 3'b001;
            a     = 8'hFF;
         end else begin
            start = 1'b0;
         end
         tick();
         if (done) begin
            dones++;
            done_at   = n;
            cap_res   = result;
            cap_flags = flags;
         end
      end
      chk("ignore.dones", 16'(dones), 16'd1);
      chk("ignore.latency", 16'(done_at), 16'd9);
      chk("ignore.result", {4'd0, cap_flags, cap_res}, {4'd0, 4'b1000, 8'hCC});

      // reset four cycles into a MUL aborts it with no write strobe
      start = 1'b1;
      op    = 3'b110;
      a     = 8'hFF;
      b     = 8'hFF;
      tick();
      start = 1'b0;
      repeat (4) tick();
      chk("abort.busy", {15'd0, busy}, 16'd1);
      rst_n = 1'b0;
      #1;
      chk("abort.outputs", {3'd0, busy, done, wen, flags, result}, 16'd0);
      wens = 0;
      repeat (2) begin
         tick();
         if (wen || done) wens++;
      end
      rst_n = 1'b1;
      repeat (12) begin
         tick();
         if (wen || done || busy) wens++;
      end
      chk("abort.nowen", 16'(wens), 16'd0);
      do_op("add0102", 3'b001, 8'h01, 8'h02, 1, 8'h03, 4'b0000, 1'b1);

      do_op("rsvd5a",  3'b111, 8'h5A, 8'hC3, 1, 8'h5A, 4'b0000, 1'b0);
      do_op("andf03c", 3'b011, 8'hF0, 8'h3C, 1, 8'h30, 4'b0000, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
